// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared encodings for the memory arbiter slice.
//   ARB_IDLE / ARB_ISSUE / ARB_RESP : arbiter FSM state encoding
//   OWNER_F / OWNER_D               : owner encoding (fetch / data port)
//   WMASK_WIDTH                     : byte write-enable width
// The per-port grant counters in mem_arbiter are only built when the
// MEM_ARBITER_COUNTERS_EN macro is defined.
// -----------------------------------------------------------------------------
package riscv_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE  = 2'd0;
    localparam arb_state_t ARB_ISSUE = 2'd1;
    localparam arb_state_t ARB_RESP  = 2'd2;

    localparam logic OWNER_F = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam int WMASK_WIDTH = 4;

    // The port that did not own the memory last time.
    function automatic logic other_owner(input logic owner);
        return (owner == OWNER_F) ? OWNER_D : OWNER_F;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational grant selection between the fetch (F) and data (D) ports.
//   FETCH_PRIORITY : 0 = round-robin on a tie, 1 = F always wins a tie
//   f_req, d_req   : request inputs
//   last_owner     : port that was served most recently
//   grant_valid    : at least one request is pending
//   owner          : selected port (OWNER_F / OWNER_D)
// -----------------------------------------------------------------------------
module arb_pick
    import riscv_pkg::*;
#(
    parameter int FETCH_PRIORITY = 0
) (
    input  logic f_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic owner
);

    always_comb begin
        grant_valid = f_req | d_req;
        owner       = OWNER_F;
        if (f_req && d_req) begin
            // Tie: either fixed fetch priority, or hand the memory to the
            // port that was not served last.
            owner = (FETCH_PRIORITY != 0) ? OWNER_F : other_owner(last_owner);
        end else if (d_req) begin
            owner = OWNER_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous memory (one-cycle read latency) between
// the instruction-fetch port F (read-only) and the load/store port D.
// Accesses are serialised through IDLE -> ISSUE -> RESP; each access returns
// a one-cycle ack with read data. All outputs are registered.
//
// Optional feature: define MEM_ARBITER_COUNTERS_EN to build 16-bit wrapping
// per-port grant counters; otherwise f_grants/d_grants are tied to zero.
//
// Ports:
//   CLK, RESET           clock (rising edge), async active-low reset
//   f_req/f_addr         fetch request and byte address
//   f_ack/f_rdata        fetch done pulse and read data
//   d_req/d_addr         data request and byte address
//   d_wdata/d_wmask      store data, byte enables (0 = load)
//   d_ack/d_rdata        data done pulse and load data
//   mem_addr/mem_rstrb   registered memory address and read strobe
//   mem_wdata/mem_wmask  registered memory write data and byte mask
//   mem_rdata            memory read data, valid the cycle after mem_rstrb
//   f_grants/d_grants    grant counters
// DATA_WIDTH must be 32 because the write mask is 4 bits wide.
// -----------------------------------------------------------------------------
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FETCH_PRIORITY = 0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   f_req,
    input  logic [ADDR_WIDTH-1:0]  f_addr,
    output logic                   f_ack,
    output logic [DATA_WIDTH-1:0]  f_rdata,
    input  logic                   d_req,
    input  logic [ADDR_WIDTH-1:0]  d_addr,
    input  logic [DATA_WIDTH-1:0]  d_wdata,
    input  logic [WMASK_WIDTH-1:0] d_wmask,
    output logic                   d_ack,
    output logic [DATA_WIDTH-1:0]  d_rdata,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_rstrb,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic [WMASK_WIDTH-1:0] mem_wmask,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic [15:0]            f_grants,
    output logic [15:0]            d_grants
);

    arb_state_t             state_reg;
    logic                   owner_reg;
    logic                   last_owner_reg;
    logic                   is_store_reg;
    logic [ADDR_WIDTH-1:0]  mem_addr_reg;
    logic                   mem_rstrb_reg;
    logic [DATA_WIDTH-1:0]  mem_wdata_reg;
    logic [WMASK_WIDTH-1:0] mem_wmask_reg;
    logic                   f_ack_reg;
    logic                   d_ack_reg;
    logic [DATA_WIDTH-1:0]  f_rdata_reg;
    logic [DATA_WIDTH-1:0]  d_rdata_reg;

    logic grant_valid;
    logic pick_owner;
    logic grant_fire;

    arb_pick #(
        .FETCH_PRIORITY (FETCH_PRIORITY)
    ) u_pick (
        .f_req       (f_req),
        .d_req       (d_req),
        .last_owner  (last_owner_reg),
        .grant_valid (grant_valid),
        .owner       (pick_owner)
    );

    // Requests are only looked at in IDLE; anything arriving later waits.
    assign grant_fire = (state_reg == ARB_IDLE) && grant_valid;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= OWNER_D;
            last_owner_reg <= OWNER_D;
            is_store_reg   <= 1'b0;
            mem_addr_reg   <= '0;
            mem_rstrb_reg  <= 1'b0;
            mem_wdata_reg  <= '0;
            mem_wmask_reg  <= '0;
            f_ack_reg      <= 1'b0;
            d_ack_reg      <= 1'b0;
            f_rdata_reg    <= '0;
            d_rdata_reg    <= '0;
        end else begin
            // Acks are single-cycle pulses.
            f_ack_reg <= 1'b0;
            d_ack_reg <= 1'b0;
            case (state_reg)
                ARB_IDLE: begin
                    if (grant_fire) begin
                        owner_reg <= pick_owner;
                        if (pick_owner == OWNER_F) begin
                            mem_addr_reg  <= f_addr;
                            mem_wdata_reg <= '0;
                            mem_rstrb_reg <= 1'b1;
                            mem_wmask_reg <= '0;
                            is_store_reg  <= 1'b0;
                        end else begin
                            mem_addr_reg  <= d_addr;
                            mem_wdata_reg <= d_wdata;
                            mem_rstrb_reg <= (d_wmask == '0);
                            mem_wmask_reg <= d_wmask;
                            is_store_reg  <= (d_wmask != '0);
                        end
                        state_reg <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    // The memory samples the access at this edge; drop the
                    // strobes so it is performed exactly once.
                    mem_rstrb_reg <= 1'b0;
                    mem_wmask_reg <= '0;
                    state_reg     <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (owner_reg == OWNER_F) begin
                        f_rdata_reg <= mem_rdata;
                        f_ack_reg   <= 1'b1;
                    end else begin
                        // A store acks too, but leaves d_rdata untouched.
                        if (!is_store_reg) begin
                            d_rdata_reg <= mem_rdata;
                        end
                        d_ack_reg <= 1'b1;
                    end
                    last_owner_reg <= owner_reg;
                    state_reg      <= ARB_IDLE;
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_rstrb = mem_rstrb_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wmask = mem_wmask_reg;
    assign f_ack     = f_ack_reg;
    assign d_ack     = d_ack_reg;
    assign f_rdata   = f_rdata_reg;
    assign d_rdata   = d_rdata_reg;

`ifdef MEM_ARBITER_COUNTERS_EN
    // One wrapping counter per port, indexed by the owner encoding.
    logic [15:0] grants_reg [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_grant_cnt
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                grants_reg[gi] <= '0;
            end else if (grant_fire && (pick_owner == 1'(gi))) begin
                grants_reg[gi] <= grants_reg[gi] + 16'd1;
            end
        end
    end

    assign f_grants = grants_reg[OWNER_F];
    assign d_grants = grants_reg[OWNER_D];
`else
    assign f_grants = '0;
    assign d_grants = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. dut0 runs round-robin (FETCH_PRIORITY=0)
// and dut1 runs fixed fetch priority; each has its own behavioural memory.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b0;

    // dut0 (round-robin)
    logic        f_req = 1'b0, d_req = 1'b0;
    logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wmask = '0;
    logic        f_ack, d_ack, mem_rstrb;
    logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  mem_wmask;
    logic [15:0] f_grants, d_grants;

    // dut1 (fixed fetch priority)
    logic        p_f_req = 1'b0, p_d_req = 1'b0;
    logic [31:0] p_f_addr = '0, p_d_addr = '0, p_d_wdata = '0;
    logic [3:0]  p_d_wmask = '0;
    logic        p_f_ack, p_d_ack, p_mem_rstrb;
    logic [31:0] p_f_rdata, p_d_rdata, p_mem_addr, p_mem_wdata;
    logic [31:0] p_mem_rdata = '0;
    logic [3:0]  p_mem_wmask;
    logic [15:0] p_f_grants, p_d_grants;

    int n_vec  = 0;
    int n_fail = 0;
    int exp_fg = 0;
    int exp_dg = 0;
    logic [31:0] sb[$];

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FETCH_PRIORITY(0)) dut0 (
        .CLK(CLK), .RESET(RESET),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .f_grants(f_grants), .d_grants(d_grants)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FETCH_PRIORITY(1)) dut1 (
        .CLK(CLK), .RESET(RESET),
        .f_req(p_f_req), .f_addr(p_f_addr), .f_ack(p_f_ack), .f_rdata(p_f_rdata),
        .d_req(p_d_req), .d_addr(p_d_addr), .d_wdata(p_d_wdata), .d_wmask(p_d_wmask),
        .d_ack(p_d_ack), .d_rdata(p_d_rdata),
        .mem_addr(p_mem_addr), .mem_rstrb(p_mem_rstrb), .mem_wdata(p_mem_wdata),
        .mem_wmask(p_mem_wmask), .mem_rdata(p_mem_rdata),
        .f_grants(p_f_grants), .d_grants(p_d_grants)
    );

    // Behavioural single-port memories with one-cycle read latency.
    always @(posedge CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wmask[b])   mem0[mem_addr[9:2]][8*b +: 8]   <= mem_wdata[8*b +: 8];
            if (p_mem_wmask[b]) mem1[p_mem_addr[9:2]][8*b +: 8] <= p_mem_wdata[8*b +: 8];
        end
        if (mem_rstrb)   mem_rdata   <= mem0[mem_addr[9:2]];
        if (p_mem_rstrb) p_mem_rdata <= mem1[p_mem_addr[9:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    // One isolated access on dut0, checking the memory-side strobes, ack
    // latency/port/width and the returned data against the scoreboard.
    task automatic do_vec(input vec_t v, input int idx);
        bit          store;
        int          waited;
        logic [31:0] prev_d;
        logic [31:0] e;
        store  = v.is_d && (v.wmask != 4'h0);
        prev_d = d_rdata;
        if (!store) sb.push_back(v.exp_rdata);
        @(negedge CLK);
        if (v.is_d) begin
            d_req = 1'b1; d_addr = v.addr; d_wdata = v.wdata; d_wmask = v.wmask;
        end else begin
            f_req = 1'b1; f_addr = v.addr;
        end
        @(posedge CLK); #1;
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_rstrb", 32'(mem_rstrb), 32'(!store));
        chk("mem_wmask", 32'(mem_wmask), v.is_d ? 32'(v.wmask) : 32'd0);
        if (store) chk("mem_wdata", mem_wdata, v.wdata);
        @(posedge CLK); #1;
        chk("strobe_clear", 32'({mem_rstrb, mem_wmask}), 32'd0);
        chk("early_ack", 32'({f_ack, d_ack}), 32'd0);
        waited = 0;
        do begin
            @(posedge CLK); #1;
            waited++;
        end while (!(f_ack || d_ack) && waited < 10);
        chk("ack_latency", 32'(waited), 32'd1);
        chk("ack_port", 32'({f_ack, d_ack}), v.is_d ? 32'd1 : 32'd2);
        f_req = 1'b0; d_req = 1'b0; d_wmask = 4'h0;
        if (v.is_d) begin
            if (v.is_d) exp_dg++;
        end else begin
            exp_fg++;
        end
        if (store) begin
            chk("store_rdata_hold", d_rdata, prev_d);
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rdata", v.is_d ? d_rdata : f_rdata, e);
        end
        $display("txn %0d: %s addr=%h wmask=%h f_rdata=%h d_rdata=%h",
                 idx, v.is_d ? "D" : "F", v.addr, v.wmask, f_rdata, d_rdata);
        @(posedge CLK); #1;
        chk("ack_pulse", 32'({f_ack, d_ack}), 32'd0);
    endtask

    initial begin
        int acks;
        int cyc;
        int last_cyc;
        int waited;
        logic [31:0] e;

        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'hA500_0000 | 32'(i);
            mem1[i] = 32'hA500_0000 | 32'(i);
        end
        mem0[2] = 32'h0010_0093;

        vecs[0] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h0010_0093};
        vecs[1] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[2] = '{1'b1, 32'h0000_0040, 32'h0,         4'h0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 32'h0000_0040, 32'h1122_3344, 4'h5, 32'h0};
        vecs[4] = '{1'b1, 32'h0000_0040, 32'h0,         4'h0, 32'hDE22_BE44};
        vecs[5] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hDE22_BE44};
        vecs[6] = '{1'b0, 32'h0000_0003, 32'h0,         4'h0, 32'hA500_0000};
        vecs[7] = '{1'b1, 32'h0000_0100, 32'h0,         4'h0, 32'hA500_0040};

        // Reset state.
        #2;
        chk("rst_mem_rstrb", 32'(mem_rstrb), 32'd0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_acks", 32'({f_ack, d_ack}), 32'd0);
        chk("rst_f_rdata", f_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_grants", 32'({f_grants, d_grants}), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        // Table of isolated accesses.
        for (int i = 0; i < 8; i++) do_vec(vecs[i], i);

        // Round-robin with both ports requesting continuously.
        @(negedge CLK);
        f_req = 1'b1; f_addr = 32'h8;
        d_req = 1'b1; d_addr = 32'h40; d_wmask = 4'h0;
        acks = 0; cyc = 0; last_cyc = -1;
        while (acks < 4 && cyc < 40) begin
            @(posedge CLK); #1;
            cyc++;
            chk("ack_overlap", 32'(f_ack & d_ack), 32'd0);
            if (f_ack || d_ack) begin
                chk("rr_order", 32'(d_ack), 32'(acks % 2));
                if (d_ack) chk("rr_d_rdata", d_rdata, 32'hDE22_BE44);
                else       chk("rr_f_rdata", f_rdata, 32'h0010_0093);
                if (last_cyc >= 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'd3);
                else               chk("rr_first_latency", 32'(cyc), 32'd3);
                $display("txn rr%0d: %s ack at cycle %0d", acks, d_ack ? "D" : "F", cyc);
                last_cyc = cyc;
                acks++;
                if (d_ack) exp_dg++; else exp_fg++;
                if (acks == 4) begin
                    f_req = 1'b0; d_req = 1'b0;
                end
            end
        end
        chk("rr_ack_count", 32'(acks), 32'd4);
        f_req = 1'b0; d_req = 1'b0;
        @(posedge CLK); #1;
        chk("rr_idle", 32'({f_ack, d_ack, mem_rstrb}), 32'd0);

        // Grant counters.
`ifdef MEM_ARBITER_COUNTERS_EN
        chk("f_grants", 32'(f_grants), 32'(exp_fg));
        chk("d_grants", 32'(d_grants), 32'(exp_dg));
`else
        chk("f_grants_off", 32'(f_grants), 32'd0);
        chk("d_grants_off", 32'(d_grants), 32'd0);
`endif
        $display("txn counters: f_grants=%0d d_grants=%0d", f_grants, d_grants);

        // Reset while an access is in ISSUE.
        @(negedge CLK);
        f_req = 1'b1; f_addr = 32'h8;
        @(posedge CLK); #1;
        chk("pre_rst_rstrb", 32'(mem_rstrb), 32'd1);
        #2 RESET = 1'b0;
        #1;
        chk("rst_mid_strobes", 32'({mem_rstrb, mem_wmask}), 32'd0);
        chk("rst_mid_grants", 32'({f_grants, d_grants}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk("rst_mid_no_ack", 32'({f_ack, d_ack}), 32'd0);
        end
        @(negedge CLK);
        RESET = 1'b1;
        sb.push_back(32'h0010_0093);
        waited = 0;
        do begin
            @(posedge CLK); #1;
            waited++;
        end while (!f_ack && waited < 10);
        f_req = 1'b0;
        chk("post_rst_latency", 32'(waited), 32'd3);
        chk("post_rst_d_ack", 32'(d_ack), 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("post_rst_rdata", f_rdata, e);
        end
        $display("txn rst: f ack after %0d edges, f_rdata=%h", waited, f_rdata);
        @(posedge CLK); #1;
        chk("post_rst_pulse", 32'(f_ack), 32'd0);
`ifdef MEM_ARBITER_COUNTERS_EN
        chk("post_rst_f_grants", 32'(f_grants), 32'd1);
`else
        chk("post_rst_f_grants_off", 32'(f_grants), 32'd0);
`endif

        // Fixed fetch priority on dut1.
        @(negedge CLK);
        p_f_req = 1'b1; p_f_addr = 32'h0;
        p_d_req = 1'b1; p_d_addr = 32'h4; p_d_wmask = 4'h0;
        acks = 0; cyc = 0;
        while (acks < 4 && cyc < 40) begin
            @(posedge CLK); #1;
            cyc++;
            chk("prio_no_d_ack", 32'(p_d_ack), 32'd0);
            if (p_f_ack) begin
                chk("prio_f_rdata", p_f_rdata, 32'hA500_0000);
                $display("txn prio%0d: F ack at cycle %0d", acks, cyc);
                acks++;
                if (acks == 4) p_f_req = 1'b0;
            end
        end
        chk("prio_f_count", 32'(acks), 32'd4);
        p_f_req = 1'b0;
        waited = 0;
        do begin
            @(posedge CLK); #1;
            waited++;
            chk("prio_no_f_ack", 32'(p_f_ack), 32'd0);
        end while (!p_d_ack && waited < 10);
        p_d_req = 1'b0;
        chk("prio_d_latency", 32'(waited), 32'd3);
        chk("prio_d_rdata", p_d_rdata, 32'hA500_0001);
        $display("txn prio_d: D ack after %0d edges, d_rdata=%h", waited, p_d_rdata);
        @(posedge CLK); #1;
        chk("prio_idle", 32'({p_f_ack, p_d_ack}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
